fft_bfly_scheduler: RTL and testbench
=====================================

// Module: fft_bfly_scheduler
// PURPOSE
//  Sequences an in-place radix-2 DIT FFT over N = 2**LOG_N points held in the data RAM.
//  On start it walks every stage and every butterfly. Each butterfly issues one operand
//  pair (addr_a, addr_b) plus a twiddle ROM address (tw_add) to the butterfly datapath
//  over a valid/ready handshake.
//  A configurable drain gap between stages lets the butterfly pipeline write back before
//  the next stage reads. done pulses when the transform is complete.
// PARAMETERS
//  LOG_N  3  log2 of the FFT size. N = 2**LOG_N. Legal range is 2..10.
//  DRAIN  4  idle cycles inserted after the last issue of each stage. Equals the butterfly
//            pipeline depth. 0 means no gap.
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        reset; asynchronous, active-high
//  start        in   1        request a new transform. Sampled only in IDLE.
//  issue_ready  in   1        butterfly datapath accepts the current pair
//  issue_valid  out  1        addr_a / addr_b / tw_add / stage are valid
//  addr_a       out  LOG_N    upper-wing data address
//  addr_b       out  LOG_N    lower-wing data address, always addr_a + 2**stage
//  tw_add       out  LOG_N-1  twiddle ROM address, range 0..N/2-1
//  stage        out  clog2(LOG_N)  current stage index, 0..LOG_N-1
//  last_in_stage out 1        qualifies issue_valid: this is the final butterfly of the stage
//  busy         out  1        high in every state except IDLE
//  done         out  1        one-cycle pulse at the end of the transform
// BEHAVIOUR
//  Reset (asynchronous, any state):
//   - FSM goes to IDLE.
//   - All outputs are 0, all counters are 0.
//   - A transform in flight is abandoned. No done pulse is produced.
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//   IDLE  -> ISSUE  when start=1. Loads stage=0 and k=0.
//   ISSUE: issue_valid=1. A transfer happens on a clock edge where issue_valid & issue_ready.
//    - Transfer with k < N/2-1: k <= k+1.
//    - Transfer with k = N/2-1: k <= 0. Go to DRAIN if DRAIN > 0, otherwise act as if
//      the drain has just expired.
//   DRAIN: issue_valid=0 for exactly DRAIN cycles. On expiry:
//    - stage < LOG_N-1: stage <= stage+1, go to ISSUE.
//    - stage = LOG_N-1: go to DONE.
//   DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
//  Address generation (k = butterfly counter, 0..N/2-1; s = stage):
//   - half = 2**s
//   - j = k mod half
//   - g = k >> s
//   - addr_a = (g << (s+1)) | j
//   - addr_b = addr_a | half
//   - tw_add = j << (LOG_N-1-s), truncated to LOG_N-1 bits
//   - Outputs are registered. They are derived from the next k and s, so they change only
//     on a transfer or a stage change.
//  Handshake:
//   - While issue_valid=1 and issue_ready=0, every output holds stable.
//   - issue_valid never drops without a transfer.
//   - issue_ready is ignored outside ISSUE.
//  Latency:
//   - start at edge T gives issue_valid=1 from T+1.
//   - With issue_ready held at 1: done is high during cycle T+1+LOG_N*(N/2+DRAIN),
//     then busy falls.
//  Boundaries:
//   - start while busy is ignored. It is not queued.
//   - start asserted in the DONE cycle is also ignored.
//   - start held high continuously re-triggers in the cycle after DONE.
//   - k wraps only at N/2-1. stage never exceeds LOG_N-1.
//   - last_in_stage = issue_valid & (k = N/2-1).
//   - stage holds its final value LOG_N-1 through DONE. It clears to 0 on re-entry to IDLE.
// TESTING
//  1. LOG_N=3, DRAIN=0, ready=1, start pulse -> exactly 12 transfers:
//     stage0 (0,1,t0)(2,3,t0)(4,5,t0)(6,7,t0);
//     stage1 (0,2,t0)(1,3,t2)(4,6,t0)(5,7,t2);
//     stage2 (0,4,t0)(1,5,t1)(2,6,t2)(3,7,t3); then one done pulse.
//  2. Same run, DRAIN=4 -> three 4-cycle gaps with issue_valid=0. done is high exactly
//     25 cycles after the start edge.
//  3. issue_ready random 50% -> same 12-pair sequence. Outputs stay stable during every
//     stall cycle (checked with an assertion).
//  4. start pulsed mid-stage1 and again in the DONE cycle -> no effect. Exactly one done
//     pulse and 12 transfers.
//  5. reset asserted asynchronously in stage1 while valid=1 -> all outputs 0 immediately.
//     A new start then restarts at stage0 (0,1,t0).
//  6. LOG_N=4, DRAIN=0 -> 32 transfers. Stage3 pair k=5 is (5,13,t5). busy is high
//     across all 33 cycles.

Source files
------------

// File: rtl/fft_bfly_scheduler.sv
// Butterfly issue sequencer for an in-place radix-2 DIT FFT over N = 2**LOG_N points.
// Walks stages and butterflies, emitting operand/twiddle addresses over valid/ready.
module fft_bfly_scheduler #(
   parameter int LOG_N = 3,
   parameter int DRAIN = 4,
   localparam int ST_W = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic             start_i,
   input  logic             issue_ready_i,
   output logic             issue_valid_o,
   output logic [LOG_N-1:0] addr_a_o,
   output logic [LOG_N-1:0] addr_b_o,
   output logic [LOG_N-2:0] tw_add_o,
   output logic [ST_W-1:0]  stage_o,
   output logic             last_in_stage_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [1:0]       state_o
);

   // Handshake: a pair transfers on a rising edge where issue_valid_o & issue_ready_i;
   // once raised, issue_valid_o and all address outputs hold until that transfer.

   localparam int K_W    = LOG_N - 1;
   localparam int HALF_N = 2 ** (LOG_N - 1);
   localparam int CNT_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [K_W-1:0]  K_LAST     = K_W'(HALF_N - 1);
   localparam logic [ST_W-1:0] STAGE_LAST = ST_W'(LOG_N - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DRAIN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [ST_W-1:0]  stage_q, stage_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stage_end;

   logic             valid_q, last_q, busy_q, done_q;
   logic [LOG_N-1:0] addr_a_q, addr_b_q;
   logic [LOG_N-2:0] tw_q;

   logic [LOG_N-1:0] kx, half, j, g, a_d, b_d, tw_full;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      stage_d   = stage_q;
      cnt_d     = cnt_q;
      stage_end = 1'b0;
      case (state_q)
         S_IDLE: begin
            k_d     = '0;
            stage_d = '0;
            cnt_d   = '0;
            if (start_i) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (issue_ready_i) begin
               if (k_q == K_LAST) begin
                  k_d   = '0;
                  cnt_d = '0;
                  if (DRAIN == 0) stage_end = 1'b1;
                  else            state_d   = S_DRAIN;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (cnt_q == CNT_LAST) stage_end = 1'b1;
            else                   cnt_d     = cnt_q + 1'b1;
         end
         S_DONE: begin
            stage_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Drain expiry (or a zero-length drain) advances the stage or finishes.
      if (stage_end) begin
         if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
         end else begin
            stage_d = stage_q + 1'b1;
            state_d = S_ISSUE;
         end
      end
   end

   // Addresses are computed from the next k/stage so the registered outputs line up.
   always_comb begin
      kx      = {1'b0, k_d};
      half    = LOG_N'(1) << stage_d;
      j       = kx & (half - 1'b1);
      g       = kx >> stage_d;
      a_d     = (g << (int'(stage_d) + 1)) | j;
      b_d     = a_d | half;
      tw_full = j << (LOG_N - 1 - int'(stage_d));
   end

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         stage_q  <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         tw_q     <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         stage_q  <= stage_d;
         cnt_q    <= cnt_d;
         valid_q  <= (state_d == S_ISSUE);
         last_q   <= (state_d == S_ISSUE) && (k_d == K_LAST);
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
         addr_a_q <= (state_d == S_IDLE) ? '0 : a_d;
         addr_b_q <= (state_d == S_IDLE) ? '0 : b_d;
         tw_q     <= (state_d == S_IDLE) ? '0 : tw_full[LOG_N-2:0];
      end
   end

   assign issue_valid_o   = valid_q;
   assign addr_a_o        = addr_a_q;
   assign addr_b_o        = addr_b_q;
   assign tw_add_o        = tw_q;
   assign stage_o         = stage_q;
   assign last_in_stage_o = last_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Bench for fft_bfly_scheduler: three configurations driven against a textbook DIT
// butterfly enumeration, with random backpressure, start-ignore and async-reset cases.
module tb_fft_bfly_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [2:0] start_s;
   logic [2:0] ready_s;

   // instance 0: LOG_N=3 DRAIN=0
   logic       w0_v, w0_last, w0_busy, w0_done;
   logic [2:0] w0_aa, w0_ab;
   logic [1:0] w0_tw, w0_st, w0_state;
   // instance 1: LOG_N=3 DRAIN=4
   logic       w1_v, w1_last, w1_busy, w1_done;
   logic [2:0] w1_aa, w1_ab;
   logic [1:0] w1_tw, w1_st, w1_state;
   // instance 2: LOG_N=4 DRAIN=0
   logic       w2_v, w2_last, w2_busy, w2_done;
   logic [3:0] w2_aa, w2_ab;
   logic [2:0] w2_tw;
   logic [1:0] w2_st, w2_state;

   fft_bfly_scheduler #(.LOG_N(3), .DRAIN(0)) u_dut0 (
      .clk_i(clk), .reset(reset), .start_i(start_s[0]), .issue_ready_i(ready_s[0]),
      .issue_valid_o(w0_v), .addr_a_o(w0_aa), .addr_b_o(w0_ab), .tw_add_o(w0_tw),
      .stage_o(w0_st), .last_in_stage_o(w0_last), .busy_o(w0_busy), .done_o(w0_done),
      .state_o(w0_state));

   fft_bfly_scheduler #(.LOG_N(3), .DRAIN(4)) u_dut1 (
      .clk_i(clk), .reset(reset), .start_i(start_s[1]), .issue_ready_i(ready_s[1]),
      .issue_valid_o(w1_v), .addr_a_o(w1_aa), .addr_b_o(w1_ab), .tw_add_o(w1_tw),
      .stage_o(w1_st), .last_in_stage_o(w1_last), .busy_o(w1_busy), .done_o(w1_done),
      .state_o(w1_state));

   fft_bfly_scheduler #(.LOG_N(4), .DRAIN(0)) u_dut2 (
      .clk_i(clk), .reset(reset), .start_i(start_s[2]), .issue_ready_i(ready_s[2]),
      .issue_valid_o(w2_v), .addr_a_o(w2_aa), .addr_b_o(w2_ab), .tw_add_o(w2_tw),
      .stage_o(w2_st), .last_in_stage_o(w2_last), .busy_o(w2_busy), .done_o(w2_done),
      .state_o(w2_state));

   // Outputs must hold while a valid pair is stalled.
   a_stall_stable: assert property (@(posedge clk) disable iff (reset)
      (w0_v && !ready_s[0]) |=> (w0_v && $stable(w0_aa) && $stable(w0_ab) &&
                                $stable(w0_tw) && $stable(w0_st) && $stable(w0_last)))
      else $error("stall stability violated on instance 0");

   typedef struct {
      logic       v, last, busy, done;
      logic [7:0] aa, ab, tw, st, state;
   } obs_t;

   int n_cmp = 0;
   int n_bad = 0;
   logic [39:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic sample(input int inst, output obs_t o);
      case (inst)
         0: begin
            o.v = w0_v; o.last = w0_last; o.busy = w0_busy; o.done = w0_done;
            o.aa = 8'(w0_aa); o.ab = 8'(w0_ab); o.tw = 8'(w0_tw); o.st = 8'(w0_st);
            o.state = 8'(w0_state);
         end
         1: begin
            o.v = w1_v; o.last = w1_last; o.busy = w1_busy; o.done = w1_done;
            o.aa = 8'(w1_aa); o.ab = 8'(w1_ab); o.tw = 8'(w1_tw); o.st = 8'(w1_st);
            o.state = 8'(w1_state);
         end
         default: begin
            o.v = w2_v; o.last = w2_last; o.busy = w2_busy; o.done = w2_done;
            o.aa = 8'(w2_aa); o.ab = 8'(w2_ab); o.tw = 8'(w2_tw); o.st = 8'(w2_st);
            o.state = 8'(w2_state);
         end
      endcase
   endtask

   // Reference: each stage pairs every index i whose bit s is clear with i + 2**s,
   // in ascending i; twiddle exponent is (i mod 2**s) * N / 2**(s+1).
   function automatic void build_exp(input int log_n);
      int n, half, idx, tw;
      n = 1 << log_n;
      exp_q.delete();
      for (int s = 0; s < log_n; s++) begin
         half = 1 << s;
         idx  = 0;
         for (int i = 0; i < n; i++) begin
            if (((i >> s) & 1) == 0) begin
               tw = (i % half) * (n >> (s + 1));
               exp_q.push_back({7'd0, (idx == n / 2 - 1) ? 1'b1 : 1'b0,
                                8'(s), 8'(i), 8'(i + half), 8'(tw)});
               idx++;
            end
         end
      end
   endfunction

   task automatic check_idle(input int inst, input string tag);
      obs_t o;
      sample(inst, o);
      check({tag, "_valid"}, o.v, 0);
      check({tag, "_busy"}, o.busy, 0);
      check({tag, "_done"}, o.done, 0);
      check({tag, "_addr_a"}, o.aa, 0);
      check({tag, "_stage"}, o.st, 0);
   endtask

   // start_mode 1: extra start pulses mid-stage1 and in the DONE cycle, both ignored.
   task automatic run(input int inst, input int log_n, input int drain,
                      input int ready_pct, input int start_mode);
      obs_t o, prev;
      logic [39:0] e;
      int exp_n, exp_done, xf, dn;
      bit stalled, finished;
      exp_n    = log_n * (1 << (log_n - 1));
      exp_done = 1 + log_n * ((1 << (log_n - 1)) + drain);
      xf = 0; dn = 0; stalled = 0; finished = 0;
      build_exp(log_n);
      @(negedge clk);
      check_idle(inst, "pre_start");
      start_s[inst] = 1'b1;
      @(posedge clk);
      #1 start_s[inst] = 1'b0;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         sample(inst, o);
         if (stalled) begin
            check("stall_valid", o.v, 1);
            check("stall_addr_a", o.aa, prev.aa);
            check("stall_addr_b", o.ab, prev.ab);
            check("stall_tw", o.tw, prev.tw);
            check("stall_stage", o.st, prev.st);
            check("stall_last", o.last, prev.last);
         end
         start_s[inst] = (start_mode == 1) && (c == 6 || o.done);
         if (o.done) begin
            dn++;
            check("done_stage", o.st, log_n - 1);
            check("done_busy", o.busy, 1);
            check("done_novalid", o.v, 0);
            if (dn == 1 && ready_pct == 100) check("done_cycle", c, exp_done);
         end else if (dn > 0) begin
            check("busy_fall", o.busy, 0);
            check("idle_stage", o.st, 0);
            finished = 1;
            break;
         end else begin
            check("busy_run", o.busy, 1);
         end
         ready_s[inst] = ($urandom_range(0, 99) < ready_pct);
         stalled = o.v && !ready_s[inst];
         prev = o;
         if (o.v && ready_s[inst]) begin
            xf++;
            if (exp_q.size() == 0) begin
               check("extra_xfer", xf, exp_n);
            end else begin
               e = exp_q.pop_front();
               check("addr_a", o.aa, e[23:16]);
               check("addr_b", o.ab, e[15:8]);
               check("tw_add", o.tw, e[7:0]);
               check("stage", o.st, e[31:24]);
               check("last_in_stage", o.last, e[32]);
            end
         end
      end
      start_s[inst] = 1'b0;
      if (!finished) check("run_timeout", 0, 1);
      check("xfer_count", xf, exp_n);
      check("done_count", dn, 1);
      check("exp_left", exp_q.size(), 0);
   endtask

   task automatic reset_mid_stage1();
      obs_t o;
      bit found;
      found = 0;
      @(negedge clk);
      ready_s[0] = 1'b1;
      start_s[0] = 1'b1;
      @(posedge clk);
      #1 start_s[0] = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         sample(0, o);
         if (o.v && o.st == 8'd1) begin
            found = 1;
            break;
         end
      end
      if (!found) check("t5_reach_stage1", 0, 1);
      #2 reset = 1'b1;
      #1 sample(0, o);
      check("rst_valid", o.v, 0);
      check("rst_addr_a", o.aa, 0);
      check("rst_addr_b", o.ab, 0);
      check("rst_tw", o.tw, 0);
      check("rst_stage", o.st, 0);
      check("rst_last", o.last, 0);
      check("rst_busy", o.busy, 0);
      check("rst_done", o.done, 0);
      check("rst_state", o.state, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      ready_s[0] = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      start_s = '0;
      ready_s = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle(0, "reset0");
      check_idle(2, "reset2");
      reset = 1'b0;

      run(0, 3, 0, 100, 0);
      run(1, 3, 4, 100, 0);
      run(0, 3, 0, 50, 0);
      run(0, 3, 0, 50, 0);
      run(0, 3, 0, 100, 1);
      reset_mid_stage1();
      run(0, 3, 0, 100, 0);
      run(2, 4, 0, 100, 0);
      run(1, 3, 4, 50, 0);
      run(2, 4, 0, 40, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
